hazard_unit: RTL
================

Name: hazard_unit

Overview:
- Pipeline hazard controller for the 5-stage MIPS core.
- Consumes the decoded control that the decode/control path pipelines down E/M/W, and drives the stall, flush and forwarding signals that the control path and datapath pipeline registers take back.
- Branch and jump redirects resolve in M.
- A multi-cycle divider in E is sequenced by an internal busy FSM that freezes F/D/E and injects bubbles into M.

Parameters:
DIV_CYCLES, 32, cycles a div/divu occupies E beyond its first cycle; legal range 2..63.
DELAY_SLOT, 1, 1 = the instruction in E at redirect is the branch delay slot and is kept; 0 = it is flushed.
CNT_W, 6, width of the divide counter.

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous active-low reset
rsD, rtD  in  5  source regs of the instruction in D
rsE, rtE  in  5  source regs of the instruction in E
writeregE, writeregM, writeregW  in  5  destination regs in E/M/W
regwriteE, regwriteM, regwriteW  in  1  register write enables
memtoregE  in  1  instruction in E is a load
redirectM  in  1  taken branch/jump/jr/jal/jalr/bal resolved in M
div_startE  in  1  instruction in E is div/divu
forwardAE, forwardBE  out  2  ALU operand select: 00 = regfile, 10 = aluoutM, 01 = resultW
stallF, stallD, stallE, stallM, stallW  out  1  hold the stage register
flushD, flushE, flushM, flushW  out  1  clear the stage register to a bubble
div_busy  out  1  divider occupying E
div_doneE  out  1  one-cycle pulse: quotient/remainder valid this cycle

Behaviour:
- Stall, flush and forward outputs are combinational from the inputs and the FSM state.
- FSM states: IDLE, BUSY. Counter cnt[CNT_W-1:0].
- Reset (rst=0, asynchronous): state=IDLE, cnt=0. Outputs then depend only on inputs.
- Reset mid-divide aborts the divide: returns to IDLE with div_busy=0.
- Forwarding for forwardAE (rsE); forwardBE is identical using rtE:
  - 10 if regwriteM & writeregM!=0 & writeregM==rsE;
  - else 01 if regwriteW & writeregW!=0 & writeregW==rsE;
  - else 00.
  - M has priority over W. Register 0 never forwards.
- Load-use: lwstall = memtoregE & regwriteE & writeregE!=0 & (writeregE==rsD | writeregE==rtD). Asserts stallF, stallD, flushE for exactly one cycle. After that, the load is in W and the consumer in E, so the value comes via forward 01.
- Divide FSM:
  - IDLE & div_startE & !(redirectM & !DELAY_SLOT): divstall=1; cnt<=DIV_CYCLES-1; go BUSY.
  - BUSY & cnt!=0: divstall=1; cnt<=cnt-1.
  - BUSY & cnt==0: divstall=0; div_doneE=1; go IDLE.
  - Total stalled cycles = DIV_CYCLES; the div spends DIV_CYCLES+1 cycles in E.
  - div_startE still high in the done cycle does not retrigger. A back-to-back div entering E the next cycle starts normally from IDLE.
  - div_busy=1 whenever state==BUSY, and also in an IDLE cycle that starts a divide.
- divstall asserts stallF, stallD, stallE and flushM, so M receives bubbles.
- Redirect:
  - flushD = redirectM.
  - flushE = lwstall | (redirectM & !DELAY_SLOT).
  - With DELAY_SLOT=0 and redirectM, a div in E is flushed and does not start.
- Priority between simultaneous events:
  - redirectM deasserts stallF and stallD in the same cycle, overriding lwstall and divstall, so the PC loads the target and D is cleared.
  - On the next cycle the target sits in D and stalls normally if the divide is still busy.
- redirectM cannot occur while BUSY, because M holds bubbles. If it does occur, the rules above still apply.
- stallM, stallW and flushW are tied 0.
- No combinational path from div_startE to state bits other than through the flop next-state logic.

Test Plan:
1. add $1 in M (regwriteM=1, writeregM=1) and add $1 in W, E reads rsE=1 -> forwardAE=10. Change rsE to 0 with writeregM=0 -> forwardAE=00.
2. lw $2 in E (memtoregE=1, writeregE=2), rtD=2 -> stallF=stallD=flushE=1 for exactly one cycle. Next cycle all 0. Two cycles later the consumer in E sees forwardBE=01.
3. DIV_CYCLES=4, div_startE held high -> stallF/D/E=flushM=1 for 4 cycles, div_doneE=1 on the 5th with no stall, then IDLE. Repeat back-to-back with a second div -> second 4-cycle stall starts immediately.
4. DELAY_SLOT=0, redirectM=1 with div_startE=1 in IDLE -> flushD=flushE=1, stallF=0, div_busy=0, state stays IDLE. DELAY_SLOT=1, same stimulus -> flushD=1, flushE=0, stallF=0, divide starts, D stalls from the next cycle.
5. redirectM coincident with lwstall -> stallF=stallD=0, flushD=1, flushE=1.
6. Drop rst low at cnt=2 in BUSY -> immediately div_busy=0, state IDLE. After rst release with div_startE=0 -> no stall.

Source files
------------

// File: rtl/hazard_unit.sv
// ============================================================================
// hazard_unit
// ----------------------------------------------------------------------------
// Pipeline hazard controller for the 5-stage MIPS core. It looks at the
// decoded control travelling down E/M/W and produces the stall, flush and
// forwarding controls for the pipeline registers. It also sequences the
// multi-cycle divider in E through a small IDLE/BUSY state machine.
//
// Parameters:
//   DIV_CYCLES  cycles a div/divu occupies E beyond its first cycle (2..63)
//   DELAY_SLOT  1 = instruction in E at a redirect is the delay slot and is
//               kept, 0 = it is flushed
//   CNT_W       width of the divide counter
//
// Ports:
//   clk, rst                       clock (rising edge), async active-low reset
//   rsD, rtD                       sources of the instruction in D
//   rsE, rtE                       sources of the instruction in E
//   writeregE/M/W, regwriteE/M/W   destinations and write enables in E/M/W
//   memtoregE                      instruction in E is a load
//   redirectM                      taken branch/jump resolved in M
//   div_startE                     instruction in E is div/divu
//   forwardAE, forwardBE           ALU operand select (10 = M, 01 = W, 00 = RF)
//   stallF/D/E/M/W                 hold stage register
//   flushD/E/M/W                   clear stage register to a bubble
//   div_busy, div_doneE            divider occupying E / result valid pulse
// ============================================================================
module hazard_unit #(
    parameter int DIV_CYCLES = 32,
    parameter int DELAY_SLOT = 1,
    parameter int CNT_W      = 6
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [4:0] rsD,
    input  logic [4:0] rtD,
    input  logic [4:0] rsE,
    input  logic [4:0] rtE,
    input  logic [4:0] writeregE,
    input  logic [4:0] writeregM,
    input  logic [4:0] writeregW,
    input  logic       regwriteE,
    input  logic       regwriteM,
    input  logic       regwriteW,
    input  logic       memtoregE,
    input  logic       redirectM,
    input  logic       div_startE,
    output logic [1:0] forwardAE,
    output logic [1:0] forwardBE,
    output logic       stallF,
    output logic       stallD,
    output logic       stallE,
    output logic       stallM,
    output logic       stallW,
    output logic       flushD,
    output logic       flushE,
    output logic       flushM,
    output logic       flushW,
    output logic       div_busy,
    output logic       div_doneE
);

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    localparam logic             KEEP_SLOT = (DELAY_SLOT != 0);
    localparam logic [CNT_W-1:0] CNT_LOAD  = CNT_W'(DIV_CYCLES - 1);

    state_t           state;
    state_t           state_next;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_next;
    logic             divstall;
    logic             lwstall;
    logic             kill_slot;

    // M has priority over W because it holds the younger result; $0 is
    // hard-wired zero and must never be forwarded.
    function automatic logic [1:0] fwd_sel(input logic [4:0] src);
        if (regwriteM && (writeregM != 5'd0) && (writeregM == src)) begin
            return 2'b10;
        end else if (regwriteW && (writeregW != 5'd0) && (writeregW == src)) begin
            return 2'b01;
        end
        return 2'b00;
    endfunction

    always_comb begin
        forwardAE = fwd_sel(rsE);
        forwardBE = fwd_sel(rtE);
    end

    // A load in E whose result is needed by D holds F/D for one cycle; the
    // value then reaches the consumer through the W forwarding path.
    always_comb begin
        lwstall   = memtoregE && regwriteE && (writeregE != 5'd0) &&
                    ((writeregE == rsD) || (writeregE == rtD));
        kill_slot = redirectM && !KEEP_SLOT;
    end

    // Divider state register; an async reset aborts any divide in flight.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
        end
    end

    // The start cycle counts as the first stalled cycle, so the counter is
    // loaded with DIV_CYCLES-1 and the cnt==0 cycle is the unstalled done
    // cycle. A div that is about to be flushed by a redirect never starts.
    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        divstall   = 1'b0;
        div_busy   = 1'b0;
        div_doneE  = 1'b0;
        unique case (state)
            IDLE: begin
                if (div_startE && !kill_slot) begin
                    divstall   = 1'b1;
                    div_busy   = 1'b1;
                    cnt_next   = CNT_LOAD;
                    state_next = BUSY;
                end
            end
            BUSY: begin
                div_busy = 1'b1;
                if (cnt != '0) begin
                    divstall = 1'b1;
                    cnt_next = cnt - CNT_W'(1);
                end else begin
                    div_doneE  = 1'b1;
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // A redirect wins over both stall sources for F/D so the PC takes the
    // target and D is cleared; E keeps whatever hold the divider needs.
    always_comb begin
        stallF = (lwstall || divstall) && !redirectM;
        stallD = (lwstall || divstall) && !redirectM;
        stallE = divstall;
        stallM = 1'b0;
        stallW = 1'b0;
        flushD = redirectM;
        flushE = lwstall || kill_slot;
        flushM = divstall;
        flushW = 1'b0;
    end

endmodule
